// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction prefetch stage placed directly in front of the cpu core. It
// fetches sequential 32-bit words from a req/ack memory bus, one request at a
// time, and buffers them with their fetch addresses in a small FIFO. The core
// pops words with a valid/ready handshake and redirects the stream with
// flush + flush_addr on taken jumps.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   ADDR_STEP   increment applied to the fetch address after each word
//   RESET_PC    first fetch address after reset
//
// Ports
//   clock          in   clock, all state on the rising edge
//   reset          in   asynchronous, active-high reset
//   flush          in   discard queue and in-flight word, refetch from flush_addr
//   flush_addr     in   new fetch address, sampled while flush=1
//   mem_req        out  memory read request
//   mem_addr       out  read address, stable while mem_req=1
//   mem_ack        in   read done, mem_rdata valid in the same cycle
//   mem_rdata      in   read data
//   instr_valid    out  instr_data/instr_pc hold a valid word
//   instr_data     out  head-of-queue instruction word
//   instr_pc       out  address the head word was fetched from
//   instr_ready    in   core consumes the head when instr_valid & instr_ready
//   level          out  number of entries currently queued
//   flush_count    out  (FETCH_STATS_EN only) saturating count of flush cycles
//   discard_count  out  (FETCH_STATS_EN only) saturating count of dropped words
//
// Build option
//   FETCH_STATS_EN  when defined, adds the flush_count/discard_count outputs.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [31:0]             flush_addr,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata,
    output logic                    instr_valid,
    output logic [31:0]             instr_data,
    output logic [31:0]             instr_pc,
    input  logic                    instr_ready,
    output logic [$clog2(DEPTH):0]  level
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]             flush_count,
    output logic [15:0]             discard_count
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [31:0]         ptr_q, ptr_d;     // fetch pointer, drives mem_addr
    logic [31:0]         pend_q, pend_d;   // redirect target held while discarding

    logic [31:0]         pc_mem   [DEPTH];
    logic [31:0]         data_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [LEVEL_W-1:0]  level_next;

    logic                push;
    logic                pop;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Flush wins over both push and pop; the acked word in REQ+flush and
    // every word acked in DISCARD are simply never written.
    assign push = (state_q == ST_REQ) && mem_ack && !flush;
    assign pop  = instr_valid && instr_ready && !flush;

    always_comb begin
        if (flush) begin
            level_next = '0;
        end else begin
            level_next = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM next state
    // ------------------------------------------------------------------
    // The IDLE->REQ and REQ-stay decisions use the level after this cycle's
    // push/pop, so a single pop from a full queue restarts fetching on the
    // very next cycle while a request is still only issued into a free slot.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    ptr_d   = flush_addr;
                    state_d = ST_REQ;
                end else if (level_next < DEPTH_L) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    if (mem_ack) begin
                        // Bus is free this cycle: restart directly at the target.
                        ptr_d = flush_addr;
                    end else begin
                        // Request cannot be withdrawn; let it finish and drop it.
                        pend_d  = flush_addr;
                        state_d = ST_DISCARD;
                    end
                end else if (mem_ack) begin
                    ptr_d = ptr_q + ADDR_STEP;
                    if (level_next >= DEPTH_L) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (mem_ack) begin
                    // A flush landing on the ack cycle is the newest target.
                    ptr_d   = flush ? flush_addr : pend_q;
                    state_d = ST_REQ;
                end else if (flush) begin
                    pend_d = flush_addr;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // Pointers are PTR_W bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            level_q <= level_next;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr_q]   <= ptr_q;
                    data_mem[wr_ptr_q] <= mem_rdata;
                    wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The head entry is read straight from registered storage, so it holds
    // steady while the core stalls.
    assign mem_req     = (state_q != ST_IDLE);
    assign mem_addr    = ptr_q;
    assign instr_valid = (level_q != '0);
    assign instr_data  = data_mem[rd_ptr_q];
    assign instr_pc    = pc_mem[rd_ptr_q];
    assign level       = level_q;

`ifdef FETCH_STATS_EN
    // ------------------------------------------------------------------
    // Fetch statistics
    // ------------------------------------------------------------------
    logic drop_word;

    assign drop_word = mem_ack &&
                       ((state_q == ST_DISCARD) || ((state_q == ST_REQ) && flush));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_count   <= '0;
            discard_count <= '0;
        end else begin
            if (flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
            if (drop_word && (discard_count != 16'hFFFF)) begin
                discard_count <= discard_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] ADDR_STEP = 32'd1;
    localparam logic [31:0] RESET_PC  = 32'd0;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] flush_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  level;
`ifdef FETCH_STATS_EN
    logic [15:0] flush_count;
    logic [15:0] discard_count;
`endif

    instr_fetch_queue #(
        .DEPTH     (DEPTH),
        .ADDR_STEP (ADDR_STEP),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .flush_addr    (flush_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .level         (level)
`ifdef FETCH_STATS_EN
        ,
        .flush_count   (flush_count),
        .discard_count (discard_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: transaction-level view of the prefetcher.
    logic [63:0] q[$];        // {pc, data} words the core should see, head first
    bit          m_busy;      // a bus request is outstanding
    bit          m_drop;      // outstanding request's data is to be thrown away
    logic [31:0] m_cur;       // address of the outstanding request
    logic [31:0] m_next;      // address of the next request to issue
    int          m_fc;
    int          m_dc;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_cur  = RESET_PC;
        m_next = RESET_PC;
        m_fc   = 0;
        m_dc   = 0;
    endtask

    task automatic model_edge(input logic f, input logic [31:0] fa, input logic ack,
                              input logic rdy);
        bit pop;
        bit acc;
        pop = (q.size() != 0) && rdy;
        acc = m_busy && ack;
        if (f && m_fc != 65535) m_fc++;
        if (acc && (f || m_drop) && m_dc != 65535) m_dc++;
        if (f) begin
            q.delete();
            if (m_busy && !ack) begin
                m_drop = 1'b1;
                m_next = fa;
            end else begin
                m_cur  = fa;
                m_next = fa;
                m_busy = 1'b1;
                m_drop = 1'b0;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && m_drop) begin
                m_cur  = m_next;
                m_drop = 1'b0;
            end else if (acc) begin
                q.push_back({m_cur, fdata(m_cur)});
                m_next = m_cur + ADDR_STEP;
                if (q.size() < DEPTH) m_cur = m_next;
                else m_busy = 1'b0;
            end else if (!m_busy && q.size() < DEPTH) begin
                m_busy = 1'b1;
                m_cur  = m_next;
            end
        end
    endtask

    task automatic check_model();
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
        if (m_busy) chk("mem_addr", mem_addr, m_cur);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
        chk("level", {29'd0, level}, q.size());
        if (q.size() != 0) begin
            chk("instr_pc", instr_pc, q[0][63:32]);
            chk("instr_data", instr_data, q[0][31:0]);
        end
`ifdef FETCH_STATS_EN
        chk("flush_count", {16'd0, flush_count}, m_fc);
        chk("discard_count", {16'd0, discard_count}, m_dc);
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic step(input logic f, input logic [31:0] fa, input logic ack,
                        input logic rdy);
        flush       = f;
        flush_addr  = fa;
        mem_ack     = ack;
        instr_ready = rdy;
        mem_rdata   = fdata(mem_addr);
        @(posedge clock);
        model_edge(f, fa, ack, rdy);
        #1;
        check_model();
    endtask

    // Asserts reset between edges and checks outputs before any edge occurs.
    task automatic do_reset();
        flush       = 1'b0;
        flush_addr  = '0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_data", instr_data, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
`ifdef FETCH_STATS_EN
        chk("rst_flush_count", {16'd0, flush_count}, 32'd0);
        chk("rst_discard_count", {16'd0, discard_count}, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic        f;
        logic        a;
        logic        r;
        logic [31:0] fa;

        reset = 1'b1;
        mem_rdata = '0;
        do_reset();

        // Streaming: ack every cycle, core always ready.
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            chk("stream_addr", mem_addr, k - 1);
            if (k >= 2) begin
                chk("stream_pc", instr_pc, k - 2);
                chk("stream_valid", {31'd0, instr_valid}, 32'd1);
            end
        end

        // Fill to DEPTH with the core stalled, then pop once.
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_req", {31'd0, mem_req}, 32'd0);
        chk("full_hold_pc", instr_pc, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        chk("refill_req", {31'd0, mem_req}, 32'd1);
        chk("refill_addr", mem_addr, 32'd4);
        chk("refill_level", {29'd0, level}, 32'd3);

        // Reset while a request is outstanding.
        chk("midreq_req", {31'd0, mem_req}, 32'd1);
        do_reset();

        // Flush while a request waits 3 cycles for its ack.
        for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b1);
        chk("discard_req", {31'd0, mem_req}, 32'd1);
        chk("discard_stale_addr", mem_addr, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("redirect_addr", mem_addr, 32'h100);
        chk("redirect_level", {29'd0, level}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("redirect_pc", instr_pc, 32'h100);
        chk("redirect_valid", {31'd0, instr_valid}, 32'd1);

        // Flush on the same cycle as ack and pop with two words queued.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("pre_flush_level", {29'd0, level}, 32'd2);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        chk("ackflush_level", {29'd0, level}, 32'd0);
        chk("ackflush_valid", {31'd0, instr_valid}, 32'd0);
        chk("ackflush_addr", mem_addr, 32'h200);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("ackflush_pc", instr_pc, 32'h200);
        chk("ackflush_data", instr_data, fdata(32'h200));

        // Fetch pointer wraps from all-ones to zero without stalling.
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("wrap_addr_hi", mem_addr, 32'hFFFF_FFFF);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("wrap_addr_lo", mem_addr, 32'd0);
        chk("wrap_req", {31'd0, mem_req}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        chk("wrap_pc", instr_pc, 32'd0);

        // Three flushes, one of them on a request still waiting for its ack.
        do_reset();
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h30, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("stats_seq_addr", mem_addr, 32'h30);
`ifdef FETCH_STATS_EN
        chk("stats_flush_count", {16'd0, flush_count}, 32'd3);
        chk("stats_discard_count", {16'd0, discard_count}, 32'd1);
`endif

        // Randomised traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            f = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 70 : 30));
            r = ($urandom_range(0, 99) < ((n / 300) % 2 == 0 ? 80 : 25));
            case ($urandom_range(0, 2))
                0:       fa = $urandom;
                1:       fa = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: fa = $urandom_range(0, 255);
            endcase
            step(f, fa, a, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
